dtc_pulse_gen: RTL and testbench



---
 rtl/tdc_pkg.sv | 16 +
 rtl/dtc_code_buf.sv | 43 ++++
 rtl/dtc_pulse_gen.sv | 159 +++++++++++++++
 tb/tb_dtc_pulse_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types for the TDC/DTC loopback path.
// Holds the default code width, the DTC FSM state type and the interval code type.
package tdc_pkg;

   localparam int TIME_W = 20;

   typedef enum logic [1:0] {
      IDLE,
      RUN_S,
      RUN_M,
      GAP
   } dtc_state_t;

   typedef logic [TIME_W-1:0] time_code_t;

endpackage

// File: rtl/dtc_code_buf.sv
// One-entry interval code buffer for dtc_pulse_gen.
// Ports: pll_clk, rst (sync, active-low), wr/wr_data (write), rd (pop),
//        rd_data (held code), full, rdy (empty), err (rejected write pulse).
module dtc_code_buf #(
   parameter int TIME_W = tdc_pkg::TIME_W
) (
   input  logic              pll_clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [TIME_W-1:0] wr_data,
   input  logic              rd,
   output logic [TIME_W-1:0] rd_data,
   output logic              full,
   output logic              rdy,
   output logic              err
);

   logic accept;

   assign accept = wr & rdy;

   // rdy is kept as its own flop so the port stays registered;
   // it is always the complement of full.
   always_ff @(posedge pll_clk) begin
      if (!rst) begin
         rd_data <= '0;
         full    <= 1'b0;
         rdy     <= 1'b1;
         err     <= 1'b0;
      end else begin
         err <= wr & ~rdy;
         if (accept) begin
            rd_data <= wr_data;
            full    <= 1'b1;
            rdy     <= 1'b0;
         end else if (rd) begin
            full <= 1'b0;
            rdy  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/dtc_pulse_gen.sv
// Digital-to-time pulse pair generator: signal rises at load, mod rises T cycles later.
// Ports: pll_clk, rst (sync, active-low), in_time/in_wr/in_rdy (code write),
//        signal, mod, busy, done, err. Optional DTC_REPEAT_EN adds input rep.
module dtc_pulse_gen
   import tdc_pkg::*;
#(
   parameter int TIME_W  = tdc_pkg::TIME_W,
   parameter int PULSE_W = 4,
   parameter int GAP_CYC = 8
) (
   input  logic              pll_clk,
   input  logic              rst,
   input  logic [TIME_W-1:0] in_time,
   input  logic              in_wr,
`ifdef DTC_REPEAT_EN
   input  logic              rep,
`endif
   output logic              in_rdy,
   output logic              signal,
   output logic              mod,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [TIME_W-1:0] ONE   = TIME_W'(1);
   localparam logic [TIME_W-1:0] P_CNT = TIME_W'(PULSE_W);
   localparam logic [TIME_W-1:0] G_CNT = TIME_W'(GAP_CYC);

   dtc_state_t        state;
   dtc_state_t        state_d;
   logic [TIME_W-1:0] cnt;
   logic [TIME_W-1:0] cnt_d;
   logic [TIME_W-1:0] buf_data;
   logic [TIME_W-1:0] load_t;
   logic              buf_full;
   logic              buf_rd;
   logic              launch;
   logic              load;
   logic              signal_d;
   logic              mod_d;
   logic              busy_d;
   logic              done_d;

   dtc_code_buf #(
      .TIME_W (TIME_W)
   ) u_buf (
      .pll_clk (pll_clk),
      .rst     (rst),
      .wr      (in_wr),
      .wr_data (in_time),
      .rd      (buf_rd),
      .rd_data (buf_data),
      .full    (buf_full),
      .rdy     (in_rdy),
      .err     (err)
   );

`ifdef DTC_REPEAT_EN
   logic [TIME_W-1:0] last_t;
   logic              rep_pend;

   // A buffered code always wins over relaunching the previous one.
   assign launch = buf_full | rep_pend;
   assign load_t = buf_full ? buf_data : last_t;

   always_ff @(posedge pll_clk) begin
      if (!rst) begin
         last_t   <= '0;
         rep_pend <= 1'b0;
      end else begin
         if (load) last_t <= load_t;
         if (done_d) rep_pend <= rep;
         else if (load) rep_pend <= 1'b0;
      end
   end
`else
   assign launch = buf_full;
   assign load_t = buf_data;
`endif

   assign load   = (state == IDLE) & launch;
   assign buf_rd = (state == IDLE) & buf_full;

   always_ff @(posedge pll_clk) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         signal <= 1'b0;
         mod    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         signal <= signal_d;
         mod    <= mod_d;
         busy   <= busy_d;
         done   <= done_d;
      end
   end

   // Each timed state reloads cnt with its length on entry and
   // leaves on the edge where cnt reads 1, so T needs no extra bit.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      unique case (state)
         IDLE: begin
            if (launch) begin
               if (load_t == '0) begin
                  state_d = RUN_M;
                  cnt_d   = P_CNT;
               end else begin
                  state_d = RUN_S;
                  cnt_d   = load_t;
               end
            end
         end
         RUN_S: begin
            if (cnt == ONE) begin
               state_d = RUN_M;
               cnt_d   = P_CNT;
            end else begin
               cnt_d = cnt - ONE;
            end
         end
         RUN_M: begin
            if (cnt == ONE) begin
               state_d = GAP;
               cnt_d   = G_CNT;
            end else begin
               cnt_d = cnt - ONE;
            end
         end
         GAP: begin
            if (cnt == ONE) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt - ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered copies of the next-state decode.
   always_comb begin
      signal_d = (state_d == RUN_S) || (state_d == RUN_M);
      mod_d    = (state_d == RUN_M);
      busy_d   = (state_d != IDLE);
      done_d   = (state == GAP) && (state_d == IDLE);
   end

endmodule

// File: tb/tb_dtc_pulse_gen.sv
// Self-checking bench for dtc_pulse_gen (PULSE_W=4, GAP_CYC=8, TIME_W=8).
// Table of single-code vectors plus directed back-to-back, err, reset and repeat sequences.
module tb_dtc_pulse_gen;

   localparam int TW = 8;

   logic          pll_clk = 1'b0;
   logic          rst     = 1'b0;
   logic [TW-1:0] in_time = '0;
   logic          in_wr   = 1'b0;
`ifdef DTC_REPEAT_EN
   logic          rep     = 1'b0;
`endif
   logic          in_rdy;
   logic          signal;
   logic          mod;
   logic          busy;
   logic          done;
   logic          err;

   dtc_pulse_gen #(
      .TIME_W  (TW),
      .PULSE_W (4),
      .GAP_CYC (8)
   ) dut (
      .pll_clk (pll_clk),
      .rst     (rst),
      .in_time (in_time),
      .in_wr   (in_wr),
`ifdef DTC_REPEAT_EN
      .rep     (rep),
`endif
      .in_rdy  (in_rdy),
      .signal  (signal),
      .mod     (mod),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 pll_clk = ~pll_clk;

   typedef struct {
      int t;
      int sig_k;
      int mod_k;
      int fall_k;
      int done_k;
      int busy_n;
   } vec_t;

   vec_t vecs[6];

   int n_chk  = 0;
   int n_fail = 0;

   int sig_q[$];
   int mod_q[$];
   int fall_q[$];
   int done_q[$];
   int err_q[$];
   int busy_n;
   int rdy1;
   logic [5:0] rs_snap;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int q_at(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   // Leaves the bench at the negedge right after accept edge E (k=0).
   task automatic wr_code(input int t);
      @(negedge pll_clk);
      in_time = TW'(t);
      in_wr   = 1'b1;
      @(negedge pll_clk);
      in_wr   = 1'b0;
      in_time = ~TW'(t);
   endtask

   // Samples after edges E+1..E+ncyc; optional writes/reset land on edge E+k.
   task automatic trace(input int ncyc, input int wa_k = -1, input int wa_t = 0,
                        input int wb_k = -1, input int wb_t = 0,
                        input int rs_k = -1);
      logic ps;
      logic pm;
      ps = signal;
      pm = mod;
      sig_q.delete();
      mod_q.delete();
      fall_q.delete();
      done_q.delete();
      err_q.delete();
      busy_n  = 0;
      rdy1    = -1;
      rs_snap = 'x;
      for (int k = 1; k <= ncyc; k++) begin
         in_wr = 1'b0;
         rst   = 1'b1;
         if (k == wa_k) begin
            in_wr   = 1'b1;
            in_time = TW'(wa_t);
         end
         if (k == wb_k) begin
            in_wr   = 1'b1;
            in_time = TW'(wb_t);
         end
         if (k == rs_k) rst = 1'b0;
         @(negedge pll_clk);
         if (signal && !ps) sig_q.push_back(k);
         if (!signal && ps) fall_q.push_back(k);
         if (mod && !pm) mod_q.push_back(k);
         if (done) done_q.push_back(k);
         if (err) err_q.push_back(k);
         if (busy) busy_n++;
         if (k == 1) rdy1 = int'(in_rdy);
         if (k == rs_k) rs_snap = {signal, mod, busy, done, err, in_rdy};
         ps = signal;
         pm = mod;
      end
      in_wr = 1'b0;
      rst   = 1'b1;
   endtask

   initial begin
      vecs[0] = '{5,   1, 6,   10,  18,  17};
      vecs[1] = '{0,   1, 1,   5,   13,  12};
      vecs[2] = '{1,   1, 2,   6,   14,  13};
      vecs[3] = '{3,   1, 4,   8,   16,  15};
      vecs[4] = '{12,  1, 13,  17,  25,  24};
      vecs[5] = '{255, 1, 256, 260, 268, 267};

      rst = 1'b0;
      repeat (3) @(negedge pll_clk);
      check("reset_outputs", int'({signal, mod, busy, done, err, in_rdy}), 1);
      rst = 1'b1;
      @(negedge pll_clk);

      foreach (vecs[i]) begin
         wr_code(vecs[i].t);
         trace(vecs[i].t + 16);
         check($sformatf("t%0d_sig_rise", vecs[i].t), q_at(sig_q, 0), vecs[i].sig_k);
         check($sformatf("t%0d_mod_rise", vecs[i].t), q_at(mod_q, 0), vecs[i].mod_k);
         check($sformatf("t%0d_fall", vecs[i].t), q_at(fall_q, 0), vecs[i].fall_k);
         check($sformatf("t%0d_done", vecs[i].t), q_at(done_q, 0), vecs[i].done_k);
         check($sformatf("t%0d_done_cnt", vecs[i].t), done_q.size(), 1);
         check($sformatf("t%0d_busy_cyc", vecs[i].t), busy_n, vecs[i].busy_n);
         check($sformatf("t%0d_rdy_after_load", vecs[i].t), rdy1, 1);
      end

      // Back-to-back: T=3 at E, T=7 at E+2.
      wr_code(3);
      trace(50, 2, 7);
      check("b2b_sig2", q_at(sig_q, 1), 17);
      check("b2b_mod2", q_at(mod_q, 1), 24);
      check("b2b_done1", q_at(done_q, 0), 16);
      check("b2b_done2", q_at(done_q, 1), 36);
      check("b2b_no_err", err_q.size(), 0);

      // Rejected write: T=4 running, T=6 buffered, T=9 refused.
      wr_code(4);
      trace(60, 2, 6, 3, 9);
      check("rej_err_cnt", err_q.size(), 1);
      check("rej_err_k", q_at(err_q, 0), 3);
      check("rej_mod2", q_at(mod_q, 1), 24);
      check("rej_done2", q_at(done_q, 1), 36);
      check("rej_pairs", sig_q.size(), 2);

      // Reset during RUN_M with a code buffered.
      wr_code(2);
      trace(40, 2, 5, -1, 0, 4);
      check("rst_snap", int'(rs_snap), 1);
      check("rst_fall", q_at(fall_q, 0), 4);
      check("rst_pairs", sig_q.size(), 1);
      check("rst_no_done", done_q.size(), 0);

`ifdef DTC_REPEAT_EN
      rep = 1'b1;
      wr_code(2);
      trace(50, 20, 6);
      check("rep_done1", q_at(done_q, 0), 15);
      check("rep_sig2", q_at(sig_q, 1), 16);
      check("rep_mod2", q_at(mod_q, 1), 18);
      check("rep_sig3", q_at(sig_q, 2), 31);
      check("rep_mod3", q_at(mod_q, 2), 37);
      rep = 1'b0;
      trace(80);
      check("rep_stop_busy", int'(busy), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
